// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch controller bus bundle: instruction memory, redirect and decode handshake
interface fetch_ctrl_if;
  logic        en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        align_err;

  modport master (
    input  en, imem_ack, imem_rdata, redirect, redirect_pc, id_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc, pc, pc_next, align_err
  );

  modport slave (
    output en, imem_ack, imem_rdata, redirect, redirect_pc, id_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, pc, pc_next, align_err
  );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - single-outstanding instruction fetch controller
// Fetches one word at pc, holds it until decode accepts, redirect overrides everything.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        inst_valid_q;
  logic        align_err_q;

  assign pc_d = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
      inst_valid_q <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      align_err_q <= 1'b0;
      // A redirect discards any coincident ack or decode acceptance.
      if (bus.redirect) begin
        pc_q         <= {bus.redirect_pc[31:2], 2'b00};
        inst_valid_q <= 1'b0;
        align_err_q  <= |bus.redirect_pc[1:0];
        state_q      <= bus.en ? FETCH : IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.en) state_q <= FETCH;
          end
          FETCH: begin
            if (bus.imem_ack) begin
              inst_q       <= bus.imem_rdata;
              inst_pc_q    <= pc_q;
              inst_valid_q <= 1'b1;
              pc_q         <= pc_d;
              state_q      <= HOLD;
            end
          end
          HOLD: begin
            if (bus.id_ready) begin
              inst_valid_q <= 1'b0;
              state_q      <= bus.en ? FETCH : IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.imem_req   = (state_q == FETCH);
  assign bus.imem_addr  = pc_q;
  assign bus.pc         = pc_q;
  assign bus.pc_next    = pc_d;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.align_err  = align_err_q;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0: PC value loaded on reset.
REQ-002 The block SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port en  in  1  fetch enable.
REQ-005 The block SHALL have port imem_req  out  1  instruction-memory read request.
REQ-006 The block SHALL have port imem_addr  out  32  read address; always equals pc.
REQ-007 The block SHALL have port imem_ack  in  1  memory returns imem_rdata this cycle.
REQ-008 The block SHALL have port imem_rdata  in  32  instruction word.
REQ-009 The block SHALL have port redirect  in  1  branch/jump taken.
REQ-010 The block SHALL have port redirect_pc  in  32  redirect target.
REQ-011 The block SHALL have port id_ready  in  1  decode stage accepts inst.
REQ-012 The block SHALL have port inst_valid  out  1  inst/inst_pc hold a valid fetched instruction.
REQ-013 The block SHALL have port inst  out  32  fetched instruction.
REQ-014 The block SHALL have port inst_pc  out  32  address of inst.
REQ-015 The block SHALL have port pc  out  32  current fetch PC (registered).
REQ-016 The block SHALL have port pc_next  out  32  pc+4, combinational, modulo 2^32.
REQ-017 The block SHALL have port align_err  out  1  one-cycle pulse on misaligned redirect target.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH and HOLD.
REQ-019 In IDLE, en=1 SHALL move to FETCH next cycle; en=0 SHALL stay in IDLE.
REQ-020 imem_req SHALL be 1 exactly when state is FETCH; imem_addr=pc.
REQ-021 In FETCH, imem_ack=1 without redirect SHALL, next cycle: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4, state<=HOLD.
REQ-022 In FETCH, imem_ack=0 SHALL hold pc and stay in FETCH; en=0 does not abort an outstanding fetch.
REQ-023 In HOLD, id_ready=0 SHALL keep inst, inst_pc and inst_valid stable.
REQ-024 In HOLD, id_ready=1 SHALL clear inst_valid next cycle and go to FETCH if en=1, else IDLE.
REQ-025 Latency: imem_ack at cycle N SHALL give inst_valid=1 at N+1; next imem_req no earlier than N+2 (one cycle after the accepting id_ready).
REQ-026 redirect=1 SHALL have priority over all other events in every state.
REQ-027 On redirect: pc<={redirect_pc[31:2],2'b00}, inst_valid<=0, state<=FETCH if en=1 else IDLE, all next cycle.
REQ-028 imem_ack coincident with redirect SHALL be discarded: no capture, no pc+4.
REQ-029 redirect in HOLD SHALL drop the held instruction even if id_ready=1 that cycle.
REQ-030 redirect with redirect_pc[1:0]!=0 SHALL pulse align_err=1 for exactly the next cycle; otherwise align_err=0.
REQ-031 pc increment SHALL wrap: 32'hFFFFFFFC+4 = 32'h0; pc_next likewise.
REQ-032 pc SHALL change only on redirect, on accepted imem_ack or on reset.
REQ-033 inst and inst_pc SHALL change only on a captured fetch or on reset.

Reset
REQ-034 rst=1 SHALL, at the next rising edge: state=IDLE, pc=RESET_PC, inst_valid=0, inst=0, inst_pc=0, align_err=0; imem_req=0.
REQ-035 rst SHALL override redirect, imem_ack and en in the same cycle, including mid-fetch and in HOLD.

Verification
REQ-036 Reset then en=1, memory acks each request one cycle later with rdata=addr^32'hA5A5A5A5, id_ready=1 -> inst_pc sequence 0,4,8,C with matching inst; pc_next=pc+4 throughout.
REQ-037 In HOLD, id_ready=0 for 5 cycles -> inst/inst_pc/inst_valid stable, imem_req=0; id_ready=1 -> next fetch at pc=4.
REQ-038 In FETCH, redirect=1 with redirect_pc=32'h100 and imem_ack=1 same cycle -> data discarded, next imem_addr=32'h100, no inst_valid from the old fetch.
REQ-039 Redirect to 32'h203 -> pc=32'h200, align_err high exactly one cycle.
REQ-040 Redirect to 32'hFFFFFFFC, ack -> inst_pc=32'hFFFFFFFC, pc=32'h0.
REQ-041 rst=1 asserted in FETCH with imem_ack=1 -> pc=RESET_PC, inst_valid=0, state IDLE; no capture.
